// File: rtl/key_speed_selector_if.sv
// Key/step bundle between the key conditioning stage and its environment.
// The master drives the raw keys; the slave returns the debounced levels, the press pulses and the step.
interface key_speed_selector_if;
    logic [3:0] KEY;
    logic [3:0] KEY_DB;
    logic [3:0] PRESS;
    logic [3:0] STEP;
    logic       STEP_VALID;

    modport master (output KEY, input KEY_DB, PRESS, STEP, STEP_VALID);
    modport slave  (input KEY, output KEY_DB, PRESS, STEP, STEP_VALID);
endinterface

// File: rtl/key_speed_selector.sv
// Debounces four active-low push-buttons into clean press pulses.
// It also latches a one-hot step value for the downstream rate counter.
module key_speed_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    key_speed_selector_if.slave  bus
);

    localparam int unsigned N_KEYS = 4;
    // The count reaches DEBOUNCE_CYCLES-1 on the same edge that commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} db_state_t;

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    db_state_t         r_state   [N_KEYS];
    db_state_t         w_state_nxt [N_KEYS];
    logic [CNT_W-1:0]  r_cnt     [N_KEYS];
    logic [CNT_W-1:0]  w_cnt_nxt [N_KEYS];
    logic [N_KEYS-1:0] r_key_db;
    logic [N_KEYS-1:0] w_key_db_nxt;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] w_press_nxt;
    logic [N_KEYS-1:0] r_step;
    logic              r_step_valid;
    logic [N_KEYS-1:0] w_cand;
    logic              w_step_upd;

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.KEY;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                r_state[i] <= REL;
                r_cnt[i]   <= '0;
            end
            r_key_db <= '1;
            r_press  <= '0;
        end else begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_key_db <= w_key_db_nxt;
            r_press  <= w_press_nxt;
        end
    end

    // Per-key debounce: a level change must persist for the full window
    always_comb begin
        w_key_db_nxt = r_key_db;
        w_press_nxt  = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                REL: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = CHK_P;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                CHK_P: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = REL;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i]  = PRS;
                        w_cnt_nxt[i]    = '0;
                        w_key_db_nxt[i] = 1'b0;
                        w_press_nxt[i]  = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                PRS: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = CHK_R;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                CHK_R: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = PRS;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i]  = REL;
                        w_cnt_nxt[i]    = '0;
                        w_key_db_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = REL;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Lowest pressed index wins on simultaneous presses
    always_comb begin
        w_cand = '0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (r_press[i]) begin
                w_cand    = '0;
                w_cand[i] = 1'b1;
            end
        end
        w_step_upd = (|r_press) && (w_cand != r_step);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_step       <= '0;
            r_step_valid <= 1'b0;
        end else begin
            if (w_step_upd) begin
                r_step <= w_cand;
            end
            r_step_valid <= w_step_upd;
        end
    end

    assign bus.KEY_DB     = r_key_db;
    assign bus.PRESS      = r_press;
    assign bus.STEP       = r_step;
    assign bus.STEP_VALID = r_step_valid;

endmodule

// File: tb/tb_key_speed_selector.sv
// Scoreboard bench for key_speed_selector with a short debounce window.
// Stimulus pushes the expected output events; a negedge monitor pops and compares them.
module tb_key_speed_selector;

    localparam int unsigned DB = 8;

    typedef struct {
        logic [3:0] key_db;
        logic [3:0] press;
        logic [3:0] step;
        logic       sv;
        int         cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_miss;
    bit   mon_en;
    logic [3:0] prev_db;
    ev_t  exp_q[$];

    key_speed_selector_if bus ();

    key_speed_selector #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any press pulse, step pulse or debounced level change is an output event
    always @(negedge clk) begin
        if (mon_en && (bus.PRESS != 4'b0000 || bus.STEP_VALID || bus.KEY_DB != prev_db)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event cyc=%0d got db=%b press=%b step=%b sv=%b",
                         cyc, bus.KEY_DB, bus.PRESS, bus.STEP, bus.STEP_VALID);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.key_db !== bus.KEY_DB || e.press !== bus.PRESS || e.step !== bus.STEP ||
                    e.sv !== bus.STEP_VALID || e.cyc != cyc) begin
                    n_miss++;
                    $display("FAIL event cyc=%0d got db=%b press=%b step=%b sv=%b, need cyc=%0d db=%b press=%b step=%b sv=%b",
                             cyc, bus.KEY_DB, bus.PRESS, bus.STEP, bus.STEP_VALID,
                             e.cyc, e.key_db, e.press, e.step, e.sv);
                end
            end
        end
        prev_db = bus.KEY_DB;
    end

    task automatic push(input logic [3:0] db, input logic [3:0] pr, input logic [3:0] st,
                        input logic sv, input int c);
        ev_t e;
        e.key_db = db; e.press = pr; e.step = st; e.sv = sv; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic set_key(input logic [3:0] v, output int t);
        @(posedge clk);
        #1;
        bus.KEY = v;
        t = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout got %0d pending events, need 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        n_vec++;
        if (bus.KEY_DB !== 4'b1111 || bus.PRESS !== 4'b0000 || bus.STEP !== 4'b0000 ||
            bus.STEP_VALID !== 1'b0) begin
            n_miss++;
            $display("FAIL %s got db=%b press=%b step=%b sv=%b, need db=1111 press=0000 step=0000 sv=0",
                     name, bus.KEY_DB, bus.PRESS, bus.STEP, bus.STEP_VALID);
        end
    endtask

    task automatic check_level(input string name, input logic [3:0] db, input logic [3:0] st);
        @(negedge clk);
        n_vec++;
        if (bus.KEY_DB !== db || bus.STEP !== st) begin
            n_miss++;
            $display("FAIL %s got db=%b step=%b, need db=%b step=%b",
                     name, bus.KEY_DB, bus.STEP, db, st);
        end
    endtask

    initial begin
        int t;
        n_vec   = 0;
        n_miss  = 0;
        mon_en  = 1'b0;
        prev_db = 4'b1111;
        rst_n   = 1'b0;
        bus.KEY = 4'b1111;

        // Reset held while the keys toggle
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.KEY = 4'($urandom_range(0, 15));
            check_reset_outputs("reset_hold");
        end
        @(posedge clk);
        #1;
        bus.KEY = 4'b1111;
        rst_n   = 1'b1;
        repeat (4) @(posedge clk);
        mon_en = 1'b1;

        // Single press of KEY[0], then release
        set_key(4'b1110, t);
        push(4'b1110, 4'b0001, 4'b0000, 1'b0, t + 10);
        push(4'b1110, 4'b0000, 4'b0001, 1'b1, t + 11);
        repeat (20) @(posedge clk);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b0001, 1'b0, t + 10);
        drain();

        // Bounce on KEY[1] shorter than the window
        set_key(4'b1101, t);
        repeat (2) @(posedge clk);
        set_key(4'b1111, t);
        repeat (1) @(posedge clk);
        set_key(4'b1101, t);
        repeat (2) @(posedge clk);
        set_key(4'b1111, t);
        repeat (20) @(posedge clk);
        check_level("bounce_rejected", 4'b1111, 4'b0001);

        // Move step to KEY[3] so the simultaneous press below must change it
        set_key(4'b0111, t);
        push(4'b0111, 4'b1000, 4'b0001, 1'b0, t + 10);
        push(4'b0111, 4'b0000, 4'b1000, 1'b1, t + 11);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b1000, 1'b0, t + 10);
        drain();

        // Simultaneous KEY[0]+KEY[2] press: KEY[0] has priority
        set_key(4'b1010, t);
        push(4'b1010, 4'b0101, 4'b1000, 1'b0, t + 10);
        push(4'b1010, 4'b0000, 4'b0001, 1'b1, t + 11);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b0001, 1'b0, t + 10);
        drain();

        // Re-press of the active key: pulse but no step change
        set_key(4'b1110, t);
        push(4'b1110, 4'b0001, 4'b0001, 1'b0, t + 10);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b0001, 1'b0, t + 10);
        drain();

        // KEY[3] press changes step; its release leaves step alone
        set_key(4'b0111, t);
        push(4'b0111, 4'b1000, 4'b0001, 1'b0, t + 10);
        push(4'b0111, 4'b0000, 4'b1000, 1'b1, t + 11);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b1000, 1'b0, t + 10);
        drain();
        check_level("release_keeps_step", 4'b1111, 4'b1000);

        // Reset mid-debounce of KEY[2], key held through reset
        set_key(4'b1011, t);
        repeat (8) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) check_reset_outputs("reset_mid_debounce");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        t      = cyc;
        mon_en = 1'b1;
        push(4'b1011, 4'b0100, 4'b0000, 1'b0, t + 10);
        push(4'b1011, 4'b0000, 4'b0100, 1'b1, t + 11);
        drain();
        set_key(4'b1111, t);
        push(4'b1111, 4'b0000, 4'b0100, 1'b0, t + 10);
        drain();
        check_level("final_levels", 4'b1111, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
